// File: rtl/fp_pkg.sv
// Shared FP definitions: op encodings, flag bit positions, dispatcher state encoding.
package fp_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned RM_W   = 3;
    localparam int unsigned FLAG_W = 5;

    localparam logic [OP_W-1:0] FP_ADD = 2'b00;
    localparam logic [OP_W-1:0] FP_SUB = 2'b01;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [2:0] {
        ST_DRAIN   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESPOND = 3'd4
    } disp_state_e;

endpackage

// File: rtl/fp_cycle_counter.sv
// Clearable up-counter with a terminal-count compare against a per-cycle limit.
module fp_cycle_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == term_i);

endmodule

// File: rtl/fp_unit_dispatcher.sv
// Requester side of the FP unit start/done handshake: accept one request, launch the
// unit, wait for done (or time out), present the response, drain after abort.
module fp_unit_dispatcher
    import fp_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic [RM_W-1:0]   req_rm,
    output logic              unit_start,
    output logic [OP_W-1:0]   unit_op,
    output logic [XLEN-1:0]   unit_a,
    output logic [XLEN-1:0]   unit_b,
    output logic [RM_W-1:0]   unit_rm,
    input  logic              unit_done,
    input  logic [XLEN-1:0]   unit_result,
    input  logic [FLAG_W-1:0] unit_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_timeout,
    output logic              busy
);

    localparam int unsigned CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    disp_state_e       state_q, state_d;
    logic              unit_start_q, unit_start_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [RM_W-1:0]   rm_q, rm_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              timeout_q, timeout_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;
    logic [CNT_W-1:0]  cnt_term;

    // One counter serves both the drain window and the watchdog.
    assign cnt_term = (state_q == ST_DRAIN) ? CNT_W'(DRAIN_CYCLES - 1) : CNT_W'(TIMEOUT - 1);

    fp_cycle_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .tc_c   (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        unit_start_d = 1'b0;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rm_d         = rm_q;
        res_d        = res_q;
        flags_d      = flags_q;
        timeout_d    = timeout_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            ST_DRAIN: begin
                if (cnt_tc) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    state_d      = ST_LAUNCH;
                    unit_start_d = 1'b1;
                    op_d         = req_op;
                    a_d          = req_a;
                    b_d          = req_b;
                    rm_d         = req_rm;
                end
            end
            ST_LAUNCH: begin
                cnt_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // A done on the final watchdog cycle still counts as a real completion.
                if (unit_done) begin
                    res_d     = unit_result;
                    flags_d   = unit_flags;
                    timeout_d = 1'b0;
                    state_d   = ST_RESPOND;
                end else if (cnt_tc) begin
                    res_d     = '0;
                    flags_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    state_d = timeout_q ? ST_DRAIN : ST_IDLE;
                    cnt_clr = timeout_q;
                end
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_DRAIN;
            unit_start_q <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rm_q         <= '0;
            res_q        <= '0;
            flags_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_start_q <= unit_start_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rm_q         <= rm_d;
            res_q        <= res_d;
            flags_q      <= flags_d;
            timeout_q    <= timeout_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESPOND);
    assign busy        = (state_q != ST_IDLE);
    assign unit_start  = unit_start_q;
    assign unit_op     = op_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign unit_rm     = rm_q;
    assign rsp_result  = res_q;
    assign rsp_flags   = flags_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fp_unit_dispatcher.sv
// Bench for fp_unit_dispatcher: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and payloads.
module tb_fp_unit_dispatcher;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned DRAIN   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [2:0]      req_rm;
    logic            unit_start;
    logic [1:0]      unit_op;
    logic [XLEN-1:0] unit_a;
    logic [XLEN-1:0] unit_b;
    logic [2:0]      unit_rm;
    logic            unit_done;
    logic [XLEN-1:0] unit_result;
    logic [4:0]      unit_flags;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic [4:0]      rsp_flags;
    logic            rsp_timeout;
    logic            busy;

    always #5 clk = ~clk;

    fp_unit_dispatcher #(
        .XLEN         (XLEN),
        .TIMEOUT      (TIMEOUT),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_rm      (req_rm),
        .unit_start  (unit_start),
        .unit_op     (unit_op),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_rm     (unit_rm),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .unit_flags  (unit_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // number of rising edges so far

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: the transaction is described by the edge it was accepted at,
    // the edge its response appeared at, and the edge from which requests are welcome.
    bit              m_on       = 1'b0;
    bit              m_inflight = 1'b0;
    bit              m_to       = 1'b0;
    int              m_idle_from = 0;
    int              m_acc      = 0;
    int              m_resp     = -1;
    logic [1:0]      m_op  = '0;
    logic [XLEN-1:0] m_a   = '0;
    logic [XLEN-1:0] m_b   = '0;
    logic [2:0]      m_rm  = '0;
    logic [XLEN-1:0] m_res = '0;
    logic [4:0]      m_fl  = '0;

    function automatic bit m_ready(input int e);
        return m_on && !m_inflight && (e >= m_idle_from);
    endfunction

    function automatic bit m_rspv(input int e);
        return m_inflight && (m_resp >= 0) && (e >= m_resp);
    endfunction

    always @(posedge clk) begin : model
        int e;
        bit rdy;
        bit rv;
        rdy = m_ready(cyc);
        rv  = m_rspv(cyc);
        cyc = cyc + 1;
        e   = cyc;
        if (reset) begin
            m_on = 1'b1; m_inflight = 1'b0; m_to = 1'b0; m_resp = -1;
            m_idle_from = e + DRAIN;
            m_op = '0; m_a = '0; m_b = '0; m_rm = '0; m_res = '0; m_fl = '0;
        end else if (!m_on) begin
            m_inflight = 1'b0;
        end else if (rdy && req_valid) begin
            m_inflight = 1'b1; m_acc = e; m_resp = -1;
            m_op = req_op; m_a = req_a; m_b = req_b; m_rm = req_rm;
        end else if (m_inflight && m_resp < 0) begin
            // Wait cycles end at edges acc+2 .. acc+TIMEOUT+1.
            if (unit_done && e >= m_acc + 2 && e <= m_acc + TIMEOUT + 1) begin
                m_resp = e; m_res = unit_result; m_fl = unit_flags; m_to = 1'b0;
            end else if (e == m_acc + TIMEOUT + 1) begin
                m_resp = e; m_res = '0; m_fl = '0; m_to = 1'b1;
            end
        end else if (rv && rsp_ready) begin
            m_inflight  = 1'b0;
            m_idle_from = m_to ? e + DRAIN : e;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("req_ready",   64'(req_ready),   64'(m_ready(cyc)));
            chk("busy",        64'(busy),        64'(!m_ready(cyc)));
            chk("rsp_valid",   64'(rsp_valid),   64'(m_rspv(cyc)));
            chk("unit_start",  64'(unit_start),  64'(m_inflight && cyc == m_acc));
            chk("unit_op",     64'(unit_op),     64'(m_op));
            chk("unit_a",      unit_a,           m_a);
            chk("unit_b",      unit_b,           m_b);
            chk("unit_rm",     64'(unit_rm),     64'(m_rm));
            chk("rsp_result",  rsp_result,       m_res);
            chk("rsp_flags",   64'(rsp_flags),   64'(m_fl));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
        end
    end

    task automatic wait_ready(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            if (req_ready) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("ready_bound", 64'(at >= 0), 64'd1);
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("rsp_bound", 64'(at >= 0), 64'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] rm, output int acc);
        int at;
        wait_ready(at);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rm = rm;
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op; req_rm = ~rm;
    endtask

    task automatic pulse_done(input int base, input int d, input logic [63:0] res,
                              input logic [4:0] fl);
        while (cyc < base + d) @(negedge clk);
        unit_done = 1'b1; unit_result = res; unit_flags = fl;
        @(negedge clk);
        unit_done = 1'b0; unit_result = 64'hBADC0FFEE0DDF00D; unit_flags = 5'h1F;
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d", cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int acc;
        int rise;
        int rel;
        int at;
        int h;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rm = '0;
        unit_done = 1'b0; unit_result = 64'hBADC0FFEE0DDF00D; unit_flags = 5'h1F; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",      64'(busy),      64'd1);
        chk("rst_unit_a",    unit_a,         64'd0);
        reset = 1'b0;
        rel = cyc;
        wait_ready(at);
        chk("drain_after_reset", 64'(at - rel), 64'd8);

        // Normal add: 1.0 + 2.0 = 3.0, unit done 6 cycles after start
        issue(2'b00, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, acc);
        chk("add_start", 64'(unit_start), 64'd1);
        pulse_done(acc, 6, 64'h4008000000000000, 5'd0);
        wait_rsp(rise);
        chk("add_latency", 64'(rise - acc), 64'd7);
        chk("add_result",  rsp_result, 64'h4008000000000000);
        chk("add_timeout", 64'(rsp_timeout), 64'd0);
        handshake(0);
        chk("add_idle", 64'(req_ready), 64'd1);

        // Sub on short path with 5 cycles of response backpressure
        issue(2'b01, 64'h4008000000000000, 64'h3FF0000000000000, 3'd1, acc);
        pulse_done(acc, 5, 64'h4000000000000000, 5'b00001);
        wait_rsp(rise);
        chk("sub_latency", 64'(rise - acc), 64'd6);
        handshake(5);
        chk("bp_idle",   64'(req_ready), 64'd1);
        chk("bp_result", rsp_result, 64'h4000000000000000);
        chk("bp_flags",  64'(rsp_flags), 64'd1);
        chk("bp_op",     64'(unit_op), 64'd1);

        // Timeout: unit never responds
        issue(2'b00, 64'h1, 64'h2, 3'd2, acc);
        wait_rsp(rise);
        chk("to_latency", 64'(rise - acc), 64'd16);
        chk("to_flag",    64'(rsp_timeout), 64'd1);
        chk("to_result",  rsp_result, 64'd0);
        chk("to_flags",   64'(rsp_flags), 64'd0);
        handshake(0);
        h = cyc;
        chk("to_ready_low", 64'(req_ready), 64'd0);
        wait_ready(at);
        chk("to_drain_len", 64'(at - h), 64'd8);

        // Done on the final wait cycle wins over the watchdog
        issue(2'b11, 64'h5, 64'h6, 3'd4, acc);
        pulse_done(acc, 15, 64'h123456789ABCDEF0, 5'b10000);
        wait_rsp(rise);
        chk("last_latency", 64'(rise - acc), 64'd16);
        chk("last_timeout", 64'(rsp_timeout), 64'd0);
        chk("last_result",  rsp_result, 64'h123456789ABCDEF0);
        chk("last_flags",   64'(rsp_flags), 64'h10);
        handshake(0);
        chk("last_no_drain", 64'(req_ready), 64'd1);

        // Reset during WAIT; the late done must be discarded
        issue(2'b00, 64'h7, 64'h8, 3'd3, acc);
        while (cyc < acc + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        chk("mid_rst_a",      unit_a, 64'd0);
        chk("mid_rst_result", rsp_result, 64'd0);
        chk("mid_rst_busy",   64'(busy), 64'd1);
        pulse_done(rel, 2, 64'hFFFF, 5'h3);
        chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        wait_ready(at);
        chk("mid_rst_drain", 64'(at - rel), 64'd8);

        // Spurious done while idle
        unit_done = 1'b1; unit_result = 64'hAAAA; unit_flags = 5'h2;
        @(negedge clk);
        unit_done = 1'b0;
        chk("spur_ready",  64'(req_ready), 64'd1);
        chk("spur_rsp",    64'(rsp_valid), 64'd0);
        chk("spur_result", rsp_result, 64'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
